// File: rtl/dmem_pkg.sv
// Shared encodings, FSM states and alignment helper for the data-memory stage.
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        DONE = 2'b10
    } state_e;

    function automatic logic align_ok(input logic [1:0] size, input logic [1:0] a_lo);
        logic ok;
        case (size)
            SZ_BYTE: ok = 1'b1;
            SZ_HALF: ok = ~a_lo[0];
            SZ_WORD: ok = (a_lo == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/dmem_lane_fmt.sv
// Load formatter: picks byte/half/word from four fetched little-endian bytes and extends it.
module dmem_lane_fmt
    import dmem_pkg::*;
(
    input  logic [31:0] fetched_i,
    input  logic [1:0]  size_i,
    input  logic        sign_ext_i,
    output logic [31:0] data_o
);

    always_comb begin
        data_o = fetched_i;
        case (size_i)
            SZ_BYTE: data_o = {{24{sign_ext_i & fetched_i[7]}}, fetched_i[7:0]};
            SZ_HALF: data_o = {{16{sign_ext_i & fetched_i[15]}}, fetched_i[15:0]};
            default: data_o = fetched_i;
        endcase
    end

endmodule

// File: rtl/dmem_unit.sv
// Byte-addressed little-endian data memory with configurable wait states and a stall output.
module dmem_unit
    import dmem_pkg::*;
#(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        misaligned
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int CNT_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;

    logic [7:0] bytes [0:DEPTH-1];

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] a0, a1, a2, a3;
    logic [31:0]           fetched, load_data;
    logic [3:0]            be;
    logic                  aligned_req, commit, wr_en;
    logic                  addr_unused;

    assign misaligned  = req & ~align_ok(size, addr[1:0]);
    assign aligned_req = req & ~misaligned;
    assign addr_unused = ^addr[31:ADDR_WIDTH];

    // Byte lanes wrap modulo the array size.
    assign a0 = addr[ADDR_WIDTH-1:0];
    assign a1 = a0 + ADDR_WIDTH'(1);
    assign a2 = a0 + ADDR_WIDTH'(2);
    assign a3 = a0 + ADDR_WIDTH'(3);

    // The accept cycle in IDLE is the first wait state, so WAIT holds for WAIT_STATES-1 cycles.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall   = 1'b0;
        commit  = 1'b0;
        if (rst_n) begin
            case (state_q)
                IDLE: begin
                    if (aligned_req) begin
                        if (WAIT_STATES == 0) begin
                            commit = 1'b1;
                        end else begin
                            stall   = 1'b1;
                            cnt_d   = CNT_W'(WAIT_STATES - 1);
                            state_d = (WAIT_STATES == 1) ? DONE : WAIT;
                        end
                    end
                end
                WAIT: begin
                    stall = 1'b1;
                    if (cnt_q <= CNT_W'(1)) begin
                        cnt_d   = '0;
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                DONE: begin
                    commit  = 1'b1;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        case (size)
            SZ_BYTE: be = 4'b0001;
            SZ_HALF: be = 4'b0011;
            default: be = 4'b1111;
        endcase
    end

    // A store dropped by the core before DONE sees req=0 here and never writes.
    assign wr_en = commit & aligned_req & we;

    always_ff @(posedge clk) begin
        if (wr_en & be[0]) bytes[a0] <= wdata[7:0];
        if (wr_en & be[1]) bytes[a1] <= wdata[15:8];
        if (wr_en & be[2]) bytes[a2] <= wdata[23:16];
        if (wr_en & be[3]) bytes[a3] <= wdata[31:24];
    end

    assign fetched = {bytes[a3], bytes[a2], bytes[a1], bytes[a0]};

    dmem_lane_fmt u_fmt (
        .fetched_i  (fetched),
        .size_i     (size),
        .sign_ext_i (sign_ext),
        .data_o     (load_data)
    );

    assign rdata = (commit & ~misaligned) ? load_data : 32'h0;

endmodule

// File: tb/tb_dmem_unit.sv
// Scoreboard bench for dmem_unit: a 2-wait-state build and a single-cycle build side by side.
module tb_dmem_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req2, req0;
    logic        we, sx;
    logic [1:0]  size;
    logic [31:0] addr, wdata;
    logic [31:0] rdata2, rdata0;
    logic        stall2, stall0, mis2, mis0;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        mis;
        bit          chk_rd;
        string       name;
    } exp_t;

    exp_t q2[$];
    exp_t q0[$];

    always #5 clk = ~clk;

    dmem_unit #(.ADDR_WIDTH(10), .WAIT_STATES(2)) u2 (
        .clk(clk), .rst_n(rst_n), .req(req2), .we(we), .size(size), .sign_ext(sx),
        .addr(addr), .wdata(wdata), .rdata(rdata2), .stall(stall2), .misaligned(mis2)
    );

    dmem_unit #(.ADDR_WIDTH(10), .WAIT_STATES(0)) u0 (
        .clk(clk), .rst_n(rst_n), .req(req0), .we(we), .size(size), .sign_ext(sx),
        .addr(addr), .wdata(wdata), .rdata(rdata0), .stall(stall0), .misaligned(mis0)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Monitors: pop an expectation whenever an access completes.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && req2 && !stall2) begin
            if (q2.size() == 0) begin
                chk("u2_unexpected_completion", 32'd1, 32'd0);
            end else begin
                e = q2.pop_front();
                chk({e.name, "_mis"}, {31'b0, mis2}, {31'b0, e.mis});
                if (e.chk_rd) chk({e.name, "_rdata"}, rdata2, e.rdata);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && req0 && !stall0) begin
            if (q0.size() == 0) begin
                chk("u0_unexpected_completion", 32'd1, 32'd0);
            end else begin
                e = q0.pop_front();
                chk({e.name, "_mis"}, {31'b0, mis0}, {31'b0, e.mis});
                if (e.chk_rd) chk({e.name, "_rdata"}, rdata0, e.rdata);
            end
        end
    end

    task automatic access(input bit sel0, input string nm, input logic w, input logic [1:0] sz,
                          input logic s, input logic [31:0] a, input logic [31:0] d,
                          input bit chk_rd, input logic [31:0] er, input logic em, input int estall);
        exp_t e;
        int   n;
        @(posedge clk); #1;
        we = w; size = sz; sx = s; addr = a; wdata = d;
        e.rdata = er; e.mis = em; e.chk_rd = chk_rd; e.name = nm;
        if (sel0) begin q0.push_back(e); req0 = 1'b1; end
        else      begin q2.push_back(e); req2 = 1'b1; end
        n = 0;
        repeat (20) begin
            @(negedge clk);
            if (!(sel0 ? stall0 : stall2)) break;
            n++;
        end
        chk({nm, "_stall_cycles"}, n, estall);
        @(posedge clk); #1;
        req0 = 1'b0; req2 = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; req2 = 1'b0; req0 = 1'b0;
        we = 1'b0; sx = 1'b0; size = 2'b10; addr = 32'h0; wdata = 32'h0;
        #12;
        // Reset state, including an aligned request held during reset.
        req2 = 1'b1; size = 2'b10; addr = 32'd0;
        #1;
        chk("rst_stall", {31'b0, stall2}, 32'd0);
        chk("rst_rdata", rdata2, 32'h0);
        size = 2'b11;
        #1;
        chk("rst_mis_comb", {31'b0, mis2}, 32'd1);
        req2 = 1'b0; size = 2'b10;
        #6 rst_n = 1'b1;

        access(0, "sw12",  1, 2'b10, 0, 32'd12, 32'h0000_0004, 0, 32'h0, 0, 2);
        chk("bytes12_15", {u2.bytes[15], u2.bytes[14], u2.bytes[13], u2.bytes[12]}, 32'h0000_0004);
        access(0, "lw12",  0, 2'b10, 0, 32'd12, 32'h0,         1, 32'h0000_0004, 0, 2);
        access(0, "sb13",  1, 2'b00, 0, 32'd13, 32'hAAAA_AAFF, 0, 32'h0, 0, 2);
        access(0, "lb13",  0, 2'b00, 1, 32'd13, 32'h0,         1, 32'hFFFF_FFFF, 0, 2);
        access(0, "lbu13", 0, 2'b00, 0, 32'd13, 32'h0,         1, 32'h0000_00FF, 0, 2);
        chk("bytes12_kept", {24'b0, u2.bytes[12]}, 32'h0000_0004);
        access(0, "lw12b", 0, 2'b10, 1, 32'd12, 32'h0,         1, 32'h0000_FF04, 0, 2);

        access(0, "sw4",   1, 2'b10, 0, 32'd4,  32'h0000_0000, 0, 32'h0, 0, 2);
        access(0, "sh2",   1, 2'b01, 0, 32'd2,  32'h5555_8001, 0, 32'h0, 0, 2);
        access(0, "lh2",   0, 2'b01, 1, 32'd2,  32'h0,         1, 32'hFFFF_8001, 0, 2);
        access(0, "lhu2",  0, 2'b01, 0, 32'd2,  32'h0,         1, 32'h0000_8001, 0, 2);
        access(0, "sh3",   1, 2'b01, 0, 32'd3,  32'h0000_1234, 1, 32'h0, 1, 0);
        access(0, "lhu2b", 0, 2'b01, 0, 32'd2,  32'h0,         1, 32'h0000_8001, 0, 2);
        access(0, "lw4",   0, 2'b10, 0, 32'd4,  32'h0,         1, 32'h0000_0000, 0, 2);
        access(0, "lw13",  0, 2'b10, 0, 32'd13, 32'h0,         1, 32'h0, 1, 0);
        access(0, "rsvd",  0, 2'b11, 0, 32'd0,  32'h0,         1, 32'h0, 1, 0);

        // Store aborted by reset during WAIT must leave the prior word intact.
        access(0, "sw20",  1, 2'b10, 0, 32'd20, 32'h1122_3344, 0, 32'h0, 0, 2);
        @(posedge clk); #1;
        we = 1'b1; size = 2'b10; sx = 1'b0; addr = 32'd20; wdata = 32'hAABB_CCDD; req2 = 1'b1;
        @(negedge clk);
        chk("abort_stall_idle", {31'b0, stall2}, 32'd1);
        @(negedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("abort_stall_async", {31'b0, stall2}, 32'd0);
        req2 = 1'b0;
        #1 rst_n = 1'b1;
        chk("bytes20_23", {u2.bytes[23], u2.bytes[22], u2.bytes[21], u2.bytes[20]}, 32'h1122_3344);
        access(0, "lw20",  0, 2'b10, 0, 32'd20, 32'h0,         1, 32'h1122_3344, 0, 2);

        // Single-cycle build with address wrap.
        access(1, "z_sw1020",  1, 2'b10, 0, 32'd1020, 32'hDEAD_BEEF, 0, 32'h0, 0, 0);
        chk("z_bytes1020", {24'b0, u0.bytes[1020]}, 32'h0000_00EF);
        access(1, "z_lw1020",  0, 2'b10, 0, 32'd1020, 32'h0, 1, 32'hDEAD_BEEF, 0, 0);
        access(1, "z_lw2044",  0, 2'b10, 0, 32'd2044, 32'h0, 1, 32'hDEAD_BEEF, 0, 0);
        access(1, "z_lb1023",  0, 2'b00, 1, 32'd1023, 32'h0, 1, 32'hFFFF_FFDE, 0, 0);
        access(1, "z_lhu1022", 0, 2'b01, 0, 32'd1022, 32'h0, 1, 32'h0000_DEAD, 0, 0);

        repeat (2) @(posedge clk);
        chk("queues_drained", q2.size() + q0.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
